scan_chain_ctrl: RTL

- Sequencer for the 192-bit serial self-test register (parallel load when its enable is low, shift MSB-first when high, registered serial output).
- On a start request it latches a test pattern and golden value, loads the pattern into the chain, then shifts the whole chain out.
- It reassembles the serial stream, compares it bit-by-bit against the golden value, and reports pass/fail, the error count and the first failing bit.
- Sits between the self-test scheduler (start/done handshake) and the shift register.

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_cmp_acc.sv | 43 ++++
 rtl/scan_chain_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizing for the self-test scan chain sequencer.
package scan_pkg;
    localparam int SCAN_WIDTH = 192;
    localparam int SCAN_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRIME,
        SHIFT,
        CMP
    } scan_state_t;
endpackage

// File: rtl/scan_cmp_acc.sv
// Reassembles the serial read-back and tallies mismatches against the expected bits.
// Latency: each strobed bit is reflected in capture/err_cnt/first_err one cycle later.
// Backpressure: none; a bit is consumed on every cycle bit_vld is high.
module scan_cmp_acc
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH,
    parameter int CNT_W = SCAN_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic [CNT_W-1:0] bit_idx,
    input  logic             bit_in,
    input  logic             bit_exp,
    output logic [WIDTH-1:0] capture,
    output logic [CNT_W:0]   err_cnt,
    output logic [CNT_W-1:0] first_err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture   <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (clr) begin
            capture   <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (bit_vld) begin
            capture <= {capture[WIDTH-2:0], bit_in};
            if (bit_in != bit_exp) begin
                err_cnt <= err_cnt + (CNT_W+1)'(1);
                // Bits arrive MSB first, so the first miss is the highest-order one.
                if (err_cnt == '0) begin
                    first_err <= bit_idx;
                end
            end
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load/shift/compare sequencer for the serial self-test register.
// Latency: start accepted at edge T, done pulses in the cycle after edge T+WIDTH+3.
// Backpressure: start is only taken in IDLE; requests while busy are dropped, not queued.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH,
    parameter int CNT_W = SCAN_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] golden,
    output logic             rf_en,
    output logic [WIDTH-1:0] rf_data,
    input  logic             shift_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W:0]   err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic [WIDTH-1:0] capture
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] gold_q;
    logic [CNT_W-1:0] bit_idx;
    logic             accept;
    logic             shift_vld;
    logic             abort_run;

    assign bit_idx   = LAST_CNT - cnt_q;
    assign abort_run = abort && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rf_en     = 1'b1;
        busy      = 1'b1;
        accept    = 1'b0;
        shift_vld = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rf_en   = 1'b0;
                state_d = PRIME;
            end
            PRIME: state_d = SHIFT;
            SHIFT: begin
                shift_vld = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = CMP;
                end
            end
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort freezes the accumulator and keeps the chain from reloading.
        if (abort_run) begin
            state_d   = IDLE;
            rf_en     = 1'b1;
            shift_vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rf_data <= '0;
            gold_q  <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            done <= (state_q == CMP) && !abort;
            if (shift_vld && cnt_q != LAST_CNT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (accept) begin
                rf_data <= pattern;
                gold_q  <= golden;
                pass    <= 1'b0;
            end else if (abort_run) begin
                pass <= 1'b0;
            end else if (state_q == CMP) begin
                pass <= (err_cnt == '0);
            end
        end
    end

    scan_cmp_acc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cmp_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .bit_vld   (shift_vld),
        .bit_idx   (bit_idx),
        .bit_in    (shift_in),
        .bit_exp   (gold_q[bit_idx]),
        .capture   (capture),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

endmodule
